// File: rtl/net_tx_arbiter.sv
// net_tx_arbiter
//   Packet-granular round-robin arbiter that shares one TX packet interface
//   among PORTS FIFO-style requesters. A grant is held from the first word of
//   a packet up to and including its end word, so packets never interleave.
//   The output is a single registered stage (first-word-fall-through style)
//   in the tx_clk domain.
//
//   Optional feature: define NET_TX_ARB_STATS_EN to add the pkt_count port
//   with one wrapping CNT_W-bit completed-packet counter per requester.
//
// Ports
//   clk        tx_clk domain clock
//   rst_n      asynchronous active-low reset
//   in_nempty  requester i has a word available
//   in_data    requester i word, slice [i*BITS +: BITS]
//   in_end     requester i word is the last of its packet
//   in_pop     pop strobe to requester i (one-hot or zero)
//   out_nempty output register holds a valid word
//   out_data   output word
//   out_end    output word is a packet end
//   out_pop    downstream consumes the output word (ignored while empty)
//   grant      index of the current / last granted port
//   busy       arbiter is forwarding a packet
//   pkt_count  completed packets per port, slice [i*CNT_W +: CNT_W]
//              (NET_TX_ARB_STATS_EN only)

module net_tx_arbiter #(
  parameter  int PORTS = 4,
  parameter  int BITS  = 64,
  parameter  int CNT_W = 16,
  localparam int GW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PORTS-1:0]       in_nempty,
  input  logic [PORTS*BITS-1:0]  in_data,
  input  logic [PORTS-1:0]       in_end,
  output logic [PORTS-1:0]       in_pop,
  output logic                   out_nempty,
  output logic [BITS-1:0]        out_data,
  output logic                   out_end,
  input  logic                   out_pop,
  output logic [GW-1:0]          grant,
  output logic                   busy
`ifdef NET_TX_ARB_STATS_EN
  ,
  output logic [PORTS*CNT_W-1:0] pkt_count
`endif
);

  localparam int unsigned NP = PORTS;

  if (PORTS < 1 || PORTS > 16 || BITS < 1 || CNT_W < 1) begin : g_param_check
    $error("net_tx_arbiter: parameter out of range");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   grant_nxt;
  logic [GW-1:0]   cand;
  logic            found;
  logic            accept;
  logic            xfer;
  logic [BITS-1:0] sel_data;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= GW'(PORTS - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  // Next-state logic. In IDLE the search starts one past the last grant,
  // which is what produces the round-robin rotation.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    cand      = '0;
    found     = 1'b0;
    case (state)
      IDLE: begin
        for (int unsigned k = 1; k <= NP; k++) begin
          cand = GW'((32'(grant) + k) % NP);
          if (!found && in_nempty[cand]) begin
            found     = 1'b1;
            grant_nxt = cand;
            state_nxt = GRANT;
          end
        end
      end
      GRANT: begin
        if (xfer && in_end[grant]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. in_pop is combinational from out_pop so the output register can
  // be refilled in the same cycle it is drained.
  always_comb begin
    accept         = !out_nempty || out_pop;
    xfer           = (state == GRANT) && in_nempty[grant] && accept;
    in_pop         = '0;
    in_pop[grant]  = xfer;
    busy           = (state == GRANT);
    sel_data       = in_data[int'(grant)*BITS +: BITS];
  end

  // Registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_nempty <= 1'b0;
      out_data   <= '0;
      out_end    <= 1'b0;
    end else if (xfer) begin
      out_data   <= sel_data;
      out_end    <= in_end[grant];
      out_nempty <= 1'b1;
    end else if (out_pop) begin
      out_nempty <= 1'b0;
    end
  end

`ifdef NET_TX_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
    end else begin
      for (int unsigned i = 0; i < NP; i++) begin
        if (in_pop[i] && in_end[i]) begin
          pkt_count[i*CNT_W +: CNT_W] <= pkt_count[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_net_tx_arbiter.sv
// tb_net_tx_arbiter
//   Self-checking bench for net_tx_arbiter (PORTS=4, BITS=16). Requesters are
//   modelled as word queues; the expected output stream is a round-robin
//   merge of whole packets computed up front from those queues.
//   With NET_TX_ARB_STATS_EN defined the packet counters are also checked.

module tb_net_tx_arbiter;

  localparam int PORTS = 4;
  localparam int BITS  = 16;
  localparam int CNT_W = 16;
  localparam int GW    = 2;

  typedef struct packed {
    logic [3:0]      port;
    logic [BITS-1:0] data;
    logic            last;
  } word_t;

  typedef struct packed {
    logic [PORTS-1:0] mask;
    logic [GW-1:0]    exp_grant;
    logic             exp_busy;
    logic [PORTS-1:0] exp_pop;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [PORTS-1:0]      in_nempty = '0;
  logic [PORTS*BITS-1:0] in_data = '0;
  logic [PORTS-1:0]      in_end = '0;
  logic [PORTS-1:0]      in_pop;
  logic                  out_nempty;
  logic [BITS-1:0]       out_data;
  logic                  out_end;
  logic                  out_pop = 1'b0;
  logic [GW-1:0]         grant;
  logic                  busy;
`ifdef NET_TX_ARB_STATS_EN
  logic [PORTS*CNT_W-1:0] pkt_count;
`endif

  net_tx_arbiter #(
    .PORTS (PORTS),
    .BITS  (BITS),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_nempty  (in_nempty),
    .in_data    (in_data),
    .in_end     (in_end),
    .in_pop     (in_pop),
    .out_nempty (out_nempty),
    .out_data   (out_data),
    .out_end    (out_end),
    .out_pop    (out_pop),
    .grant      (grant),
    .busy       (busy)
`ifdef NET_TX_ARB_STATS_EN
    ,
    .pkt_count  (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  word_t rq[PORTS][$];
  word_t exp_q[$];
  bit    start_pkt[PORTS];
  bit    gate[PORTS];
  bit    pop_en;
  bit    rand_mode;
  int    ncyc;
  int    first_pop_cyc;
  int    first_out_cyc;
  int    xfer_cyc[$];
  int    seq;

  logic [PORTS-1:0] snap_pops;
  logic             snap_onv;
  logic [BITS-1:0]  snap_data;
  logic [GW-1:0]    snap_grant;
  logic             snap_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.port = 4'(p);
      w.data = {4'(p), 4'(seq), 8'($urandom)};
      w.last = (i == len - 1);
      rq[p].push_back(w);
    end
    seq++;
  endtask

  // Reference: whole packets taken in rotation starting after the reset
  // grant (PORTS-1), skipping requesters that have nothing left.
  function automatic void build_expected();
    word_t       tmp[PORTS][$];
    word_t       w;
    int unsigned last_p;
    bit          any;
    last_p = PORTS - 1;
    for (int p = 0; p < PORTS; p++) tmp[p] = rq[p];
    exp_q.delete();
    do begin
      any = 1'b0;
      for (int unsigned k = 1; k <= PORTS; k++) begin
        int unsigned p;
        p = (last_p + k) % PORTS;
        if (!any && tmp[p].size() > 0) begin
          any    = 1'b1;
          last_p = p;
          do begin
            w = tmp[p].pop_front();
            exp_q.push_back(w);
          end while (!w.last && tmp[p].size() > 0);
        end
      end
    end while (any);
  endfunction

  task automatic do_reset(input bit check_vals);
    @(negedge clk);
    rst_n     = 1'b0;
    in_nempty = '0;
    in_data   = '0;
    in_end    = '0;
    out_pop   = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      rq[p].delete();
      start_pkt[p] = 1'b1;
      gate[p]      = 1'b1;
    end
    exp_q.delete();
    xfer_cyc.delete();
    pop_en        = 1'b1;
    rand_mode     = 1'b0;
    first_pop_cyc = -1;
    first_out_cyc = -1;
    ncyc          = 0;
    #2;
    if (check_vals) begin
      check("rst_in_pop", in_pop, 0);
      check("rst_out_nempty", out_nempty, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_end", out_end, 0);
      check("rst_grant", grant, PORTS - 1);
      check("rst_busy", busy, 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle();
    logic [PORTS-1:0] pops;
    word_t            e;
    @(negedge clk);
    for (int p = 0; p < PORTS; p++) begin
      if (rand_mode) gate[p] = ($urandom_range(3) != 0);
      if (rq[p].size() > 0) begin
        in_nempty[p]            = start_pkt[p] || gate[p];
        in_data[p*BITS +: BITS] = rq[p][0].data;
        in_end[p]               = rq[p][0].last;
      end else begin
        in_nempty[p]            = 1'b0;
        in_data[p*BITS +: BITS] = '0;
        in_end[p]               = 1'b0;
      end
    end
    out_pop = rand_mode ? ($urandom_range(3) != 0) : pop_en;
    #1;
    pops       = in_pop;
    snap_pops  = in_pop;
    snap_onv   = out_nempty;
    snap_data  = out_data;
    snap_grant = grant;
    snap_busy  = busy;
    check("pop_onehot", 64'($onehot0(pops)), 1);
    check("pop_needs_nempty", pops & ~in_nempty, 0);
    if (pops != 0 && first_pop_cyc < 0) first_pop_cyc = ncyc;
    if (out_nempty && first_out_cyc < 0) first_out_cyc = ncyc;
    if (out_pop && out_nempty) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL extra_word: got %0h expected no word (t=%0t)", out_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_end", out_end, e.last);
        if (!rand_mode) check("grant_owner", grant, e.port);
        xfer_cyc.push_back(ncyc);
      end
    end
    @(posedge clk);
    for (int p = 0; p < PORTS; p++) begin
      if (pops[p] && rq[p].size() > 0) begin
        start_pkt[p] = rq[p][0].last;
        void'(rq[p].pop_front());
      end
    end
    ncyc++;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_nempty) && n < max_cyc) begin
      cycle();
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    cycle();
    cycle();
    check({name, "_idle_busy"}, snap_busy, 0);
  endtask

  vec_t vecs[9];

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    logic [BITS-1:0] held;
    seq = 0;

    vecs[0] = '{4'b0001, 2'd0, 1'b1, 4'b0001};
    vecs[1] = '{4'b0010, 2'd1, 1'b1, 4'b0010};
    vecs[2] = '{4'b0100, 2'd2, 1'b1, 4'b0100};
    vecs[3] = '{4'b1000, 2'd3, 1'b1, 4'b1000};
    vecs[4] = '{4'b1100, 2'd2, 1'b1, 4'b0100};
    vecs[5] = '{4'b1010, 2'd1, 1'b1, 4'b0010};
    vecs[6] = '{4'b1111, 2'd0, 1'b1, 4'b0001};
    vecs[7] = '{4'b1001, 2'd0, 1'b1, 4'b0001};
    vecs[8] = '{4'b0000, 2'd3, 1'b0, 4'b0000};

    // Reset values, then idle with no requests
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("idle_pop", snap_pops, 0);
      check("idle_busy", snap_busy, 0);
      check("idle_out_nempty", snap_onv, 0);
    end

    // First arbitration after reset for a table of request masks
    for (int i = 0; i < 9; i++) begin
      do_reset(1'b0);
      @(negedge clk);
      in_nempty = vecs[i].mask;
      in_end    = '1;
      out_pop   = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_grant", i), grant, vecs[i].exp_grant);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_pop", i), in_pop, vecs[i].exp_pop);
    end

    // Port 2, three-word packet: latency and ordering
    do_reset(1'b0);
    add_pkt(2, 3);
    build_expected();
    t0 = ncyc;
    drain("p2", 50);
    check("p2_pop_latency", first_pop_cyc - t0, 1);
    check("p2_out_latency", first_out_cyc - t0, 2);
    check("p2_grant", snap_grant, 2);
    check("p2_words", xfer_cyc.size(), 3);
    if (xfer_cyc.size() == 3) check("p2_back_to_back", xfer_cyc[2] - xfer_cyc[0], 2);

    // All ports with two-word packets, port 0 twice: rotation and one bubble
    do_reset(1'b0);
    for (int p = 0; p < PORTS; p++) add_pkt(p, 2);
    add_pkt(0, 2);
    build_expected();
    drain("rr", 100);
    check("rr_words", xfer_cyc.size(), 10);
    if (xfer_cyc.size() == 10) begin
      for (int i = 1; i < 10; i++) begin
        check($sformatf("rr_gap%0d", i), xfer_cyc[i] - xfer_cyc[i-1], (i % 2 == 1) ? 1 : 2);
      end
    end

    // Port 1 stalls mid-packet while port 3 waits
    do_reset(1'b0);
    add_pkt(1, 3);
    add_pkt(3, 2);
    build_expected();
    n = 0;
    while (start_pkt[1] && n < 20) begin
      cycle();
      n++;
    end
    check("stall_started", start_pkt[1], 0);
    gate[1] = 1'b0;
    for (int s = 0; s < 5; s++) begin
      cycle();
      check("stall_pop", snap_pops, 0);
      check("stall_grant", snap_grant, 1);
      check("stall_busy", snap_busy, 1);
      check("stall_out_nempty", snap_onv, (s == 0) ? 1 : 0);
    end
    gate[1] = 1'b1;
    drain("stall", 50);

    // Backpressure mid-packet
    do_reset(1'b0);
    add_pkt(0, 4);
    build_expected();
    n = 0;
    while (rq[0].size() > 2 && n < 20) begin
      cycle();
      n++;
    end
    check("bp_progress", rq[0].size(), 2);
    held = (exp_q.size() > 0) ? exp_q[0].data : '0;
    pop_en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      cycle();
      check("bp_pop", snap_pops, 0);
      check("bp_out_nempty", snap_onv, 1);
      check("bp_data_stable", snap_data, held);
    end
    pop_en = 1'b1;
    drain("bp", 50);

    // Randomised traffic, gaps and backpressure
    for (int it = 0; it < 25; it++) begin
      do_reset(1'b0);
      for (int p = 0; p < PORTS; p++) begin
        int np;
        np = $urandom_range(3);
        for (int k = 0; k < np; k++) add_pkt(p, $urandom_range(1, 5));
      end
      build_expected();
      rand_mode = 1'b1;
      drain($sformatf("rand%0d", it), 1000);
    end

`ifdef NET_TX_ARB_STATS_EN
    // 70000 single-word packets on port 0 wrap a 16-bit counter
    do_reset(1'b0);
    @(negedge clk);
    in_nempty[0] = 1'b1;
    in_end[0]    = 1'b1;
    out_pop      = 1'b1;
    n = 0;
    for (int c = 0; c < 200_000 && n < 70_000; c++) begin
      @(negedge clk);
      if (in_pop[0]) n++;
    end
    check("stats_pops", n, 70_000);
    @(posedge clk);
    #1;
    in_nempty = '0;
    repeat (3) @(negedge clk);
    check("stats_cnt0", pkt_count[0 +: CNT_W], 70_000 % (1 << CNT_W));
    for (int p = 1; p < PORTS; p++) begin
      check($sformatf("stats_cnt%0d", p), pkt_count[p*CNT_W +: CNT_W], 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
